// File: rtl/calc_pkg.sv
// Shared opcode, state and flag definitions for the accumulator calculator.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_EQ  = 3'b011,
    OP_AND = 3'b100,
    OP_XOR = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

endpackage

// File: rtl/calc_shift_mul.sv
// Shift-add multiplier, one multiplier bit per clock.
// Bit 0 is folded into the start cycle so the product is ready WIDTH-1 clocks later.
module calc_shift_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      run     <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a} << 1;
      mplier  <= b >> 1;
      product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      cnt     <= CW'(WIDTH - 1);
      run     <= 1'b1;
    end else if (run) begin
      if (cnt != '0) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/accum_calculator.sv
// Accumulating ALU with valid/ready handshake on both sides.
// Define CALC_MUL_EN to build the shift-add multiplier (op 110).
module accum_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_e             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flg;
  logic [3:0]         mul_flg;
  logic               is_mul;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  op_e                opc;

  assign opc       = op_e'(op);
  assign opa       = use_acc ? acc : a;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

`ifdef CALC_MUL_EN
  assign is_mul = (opc == OP_MUL);

  calc_shift_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (opa),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  always_comb begin
    sum     = {1'b0, opa} + {1'b0, b};
    dif     = {1'b0, opa} - {1'b0, b};
    alu_res = '0;
    alu_flg = '0;
    unique case (opc)
      OP_ADD: begin
        alu_res            = sum[WIDTH-1:0];
        alu_flg[FLAG_CARRY] = sum[WIDTH];
        alu_flg[FLAG_OVF]  = (opa[WIDTH-1] == b[WIDTH-1]) &&
                             (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res            = dif[WIDTH-1:0];
        alu_flg[FLAG_CARRY] = dif[WIDTH];
        alu_flg[FLAG_OVF]  = (opa[WIDTH-1] != b[WIDTH-1]) &&
                             (dif[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_OR:  alu_res = opa | b;
      OP_EQ:  alu_res = WIDTH'(opa != b);
      OP_AND: alu_res = opa & b;
      OP_XOR: alu_res = opa ^ b;
      // MUL lands here only when the multiplier is not built
      default: alu_flg[FLAG_ERR] = 1'b1;
    endcase
    alu_flg[FLAG_ZERO] = (alu_res == '0);
  end

  always_comb begin
    mul_flg            = '0;
    mul_flg[FLAG_OVF]  = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_flg[FLAG_ZERO] = (mul_prod[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc_clr) acc <= '0;
          if (in_valid) begin
            if (is_mul) begin
              state <= BUSY;
            end else begin
              state  <= DONE;
              result <= alu_res;
              flags  <= alu_flg;
              if (!alu_flg[FLAG_ERR]) acc <= alu_res;
            end
          end
        end
        BUSY: begin
          if (mul_done) begin
            state  <= DONE;
            result <= mul_prod[WIDTH-1:0];
            flags  <= mul_flg;
            acc    <= mul_prod[WIDTH-1:0];
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_calculator.sv
// Self-checking bench for accum_calculator (WIDTH=8), with or without CALC_MUL_EN.
module tb_accum_calculator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       use_acc = 1'b0;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic [3:0] flags;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  accum_calculator #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
    int         lat;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions
  function automatic void model(input int o, input int x, input int y,
                                output int r, output int f, output int lat);
    int sx, sy, s, p, err, ovf, cy;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    err = 0; ovf = 0; cy = 0; r = 0; lat = 1;
    case (o)
      0: begin
        r = (x + y) % 256; cy = int'((x + y) > 255);
        s = sx + sy; ovf = int'(s > 127 || s < -128);
      end
      1: begin
        r = (x - y + 256) % 256; cy = int'(x < y);
        s = sx - sy; ovf = int'(s > 127 || s < -128);
      end
      2: r = x | y;
      3: r = int'(x != y);
      4: r = x & y;
      5: r = x ^ y;
      6: begin
`ifdef CALC_MUL_EN
        p = x * y; r = p % 256; ovf = int'(p > 255); lat = 9;
`else
        err = 1;
`endif
      end
      default: err = 1;
    endcase
    f = err * 8 + ovf * 4 + cy * 2 + int'(r == 0);
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic ua, input logic clr,
                       output logic [7:0] r, output logic [3:0] f,
                       output int lat);
    int w;
    @(negedge clk);
    op = o; a = x; b = y; use_acc = ua; acc_clr = clr; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; acc_clr = 1'b0;
    lat = 0;
    r = '0; f = '0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    r = result; f = flags;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic clear_acc();
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic [3:0] f;
    int lat, er, ef, el, macc, ea;
    logic [2:0] ro;
    logic [7:0] ra, rb;
    logic ru, rc;
    int bad;

    tv[0]  = '{3'd0, 8'd200, 8'd100, 8'd44,  4'b0010, 1};
    tv[1]  = '{3'd1, 8'd5,   8'd5,   8'd0,   4'b0001, 1};
    tv[2]  = '{3'd3, 8'd7,   8'd7,   8'd0,   4'b0001, 1};
`ifdef CALC_MUL_EN
    tv[3]  = '{3'd6, 8'd20,  8'd15,  8'd44,  4'b0100, 9};
`else
    tv[3]  = '{3'd6, 8'd20,  8'd15,  8'd0,   4'b1001, 1};
`endif
    tv[4]  = '{3'd0, 8'd127, 8'd1,   8'd128, 4'b0100, 1};
    tv[5]  = '{3'd1, 8'd0,   8'd1,   8'd255, 4'b0010, 1};
    tv[6]  = '{3'd1, 8'd128, 8'd1,   8'd127, 4'b0100, 1};
    tv[7]  = '{3'd2, 8'hA0,  8'h0B,  8'hAB,  4'b0000, 1};
    tv[8]  = '{3'd4, 8'hF0,  8'h0F,  8'h00,  4'b0001, 1};
    tv[9]  = '{3'd5, 8'hFF,  8'hFF,  8'h00,  4'b0001, 1};
    tv[10] = '{3'd3, 8'd3,   8'd4,   8'd1,   4'b0000, 1};
    tv[11] = '{3'd7, 8'd9,   8'd9,   8'd0,   4'b1001, 1};

    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'(flags), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, 1'b0, 1'b0, r, f, lat);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(tv[i].r));
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(tv[i].f));
      chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
    end

    // Accumulator chaining, reserved op, clear
    clear_acc();
    do_op(3'd0, 8'd10, 8'd0, 1'b0, 1'b0, r, f, lat);
    chk("acc_seed", 32'(r), 10);
    do_op(3'd0, 8'd99, 8'd5, 1'b1, 1'b0, r, f, lat);
    chk("acc_add5", 32'(r), 15);
    do_op(3'd7, 8'd1, 8'd1, 1'b1, 1'b0, r, f, lat);
    chk("rsv_err", 32'(f[3]), 1);
    do_op(3'd0, 8'd0, 8'd0, 1'b1, 1'b0, r, f, lat);
    chk("acc_after_rsv", 32'(r), 15);
    clear_acc();
    do_op(3'd0, 8'd77, 8'd1, 1'b1, 1'b0, r, f, lat);
    chk("acc_after_clr", 32'(r), 1);
    do_op(3'd0, 8'd0, 8'd2, 1'b1, 1'b1, r, f, lat);
    chk("clr_with_op_old_acc", 32'(r), 3);
    do_op(3'd0, 8'd0, 8'd0, 1'b1, 1'b0, r, f, lat);
    chk("clr_with_op_load_wins", 32'(r), 3);

    // Back-pressure: result held, new request ignored
    @(negedge clk);
    op = 3'd0; a = 8'd3; b = 8'd4; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result != 8'd7 || !out_valid || in_ready) bad++;
      if (i == 1) begin
        op = 3'd0; a = 8'd1; b = 8'd1; in_valid = 1'b1;
      end
    end
    chk("hold_stable", bad, 0);
    chk("hold_result", 32'(result), 7);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("hold_release_idle", 32'(in_ready), 1);
    chk("hold_release_nvalid", 32'(out_valid), 0);
    do_op(3'd0, 8'd0, 8'd0, 1'b1, 1'b0, r, f, lat);
    chk("hold_ignored_acc", 32'(r), 7);

    // Reset in the 4th cycle of a MUL
    @(negedge clk);
    op = 3'd6; a = 8'd20; b = 8'd15; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    chk("abort_no_result", bad, 0);
    do_op(3'd0, 8'd0, 8'd0, 1'b1, 1'b0, r, f, lat);
    chk("abort_acc_zero", 32'(r), 0);

    // Randomized against the model, acc tracked in the bench
    macc = 0;
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      ru = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 7) == 0);
      ea = ru ? macc : int'(ra);
      model(int'(ro), ea, int'(rb), er, ef, el);
      if (rc) macc = 0;
      if (ef < 8) macc = er;
      do_op(ro, ra, rb, ru, rc, r, f, lat);
      chk($sformatf("rnd%0d_op%0d_result", i, ro), 32'(r), er);
      chk($sformatf("rnd%0d_op%0d_flags", i, ro), 32'(f), ef);
      chk($sformatf("rnd%0d_op%0d_latency", i, ro), lat, el);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accum_calculator.md
ACCUM_CALCULATOR -- requirements
Module: accum_calculator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand, result and accumulator width (legal values 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operation request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port op, input, 3 bits: the operation code, encoded 000 ADD, 001 SUB, 010 OR, 011 EQ, 100 AND, 101 XOR, 110 MUL, 111 reserved.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port use_acc, input, 1 bit: when high, the accumulator replaces a as the first operand.
REQ-009 The block SHALL have port acc_clr, input, 1 bit: a synchronous accumulator clear, honoured only in IDLE.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-013 The block SHALL have port flags, output, 4 bits: {err, ovf, carry, zero}.

Function
REQ-014 The state machine SHALL have states IDLE, BUSY and DONE; in_ready SHALL equal (state==IDLE).
REQ-015 On in_valid && in_ready, the block SHALL capture op, the effective operand a (acc if use_acc) and b; it SHALL go to BUSY for MUL, otherwise to DONE.
REQ-016 Single-cycle ops SHALL assert out_valid in the cycle after acceptance (latency 1).
REQ-017 MUL SHALL be computed by shift-add, one bit per cycle, so that out_valid asserts exactly WIDTH+1 cycles after acceptance.
REQ-018 In DONE, result and flags SHALL be held stable while out_valid && !out_ready; on out_valid && out_ready the block SHALL return to IDLE; the maximum rate is one op per 2 cycles.
REQ-019 ADD/SUB results SHALL be taken modulo 2^WIDTH: carry = carry-out for ADD and borrow for SUB; ovf = signed two's-complement overflow.
REQ-020 EQ SHALL return 0 when a==b and 1 otherwise, zero-extended to WIDTH.
REQ-021 MUL SHALL return the low WIDTH bits of the product; ovf = 1 if the high WIDTH bits are nonzero; carry = 0.
REQ-022 OR/AND/XOR/EQ SHALL drive carry = ovf = 0; zero = (result==0) for every op.
REQ-023 Op 111 SHALL yield result=0 and err=1 with latency 1, and the accumulator SHALL be unchanged.
REQ-024 On entering DONE with err=0, acc SHALL be loaded with result.
REQ-025 acc_clr in IDLE SHALL zero acc next cycle; when acc_clr coincides with an accepted use_acc op, the op SHALL use the old acc and the op's result load SHALL win.
REQ-026 in_valid while not in IDLE SHALL be ignored (no capture); a requester SHALL hold its request until it sees in_ready.

Reset
REQ-027 While rst_n=0 the block SHALL asynchronously force state=IDLE, acc=0, result=0, flags=0 and out_valid=0; in_ready SHALL be 1 after reset.
REQ-028 Reset asserted during BUSY or DONE SHALL abort the operation and discard the partial product; no result is emitted.

Configuration
REQ-029 With macro CALC_MUL_EN defined, MUL SHALL behave per REQ-017/REQ-021.
REQ-030 Without CALC_MUL_EN, no multiplier logic SHALL be built, BUSY SHALL be unreachable, and op 110 SHALL behave as reserved (REQ-023).

Structure
REQ-031 Package calc_pkg SHALL hold the op_e enum (op codes), the state_e enum (IDLE/BUSY/DONE) and the flag bit-index constants.
REQ-032 The shift-add multiplier SHALL be a sub-module calc_shift_mul (parameter WIDTH; start, done, 2*WIDTH product), instantiated only under CALC_MUL_EN.

Verification (WIDTH=8)
REQ-033 The bench SHALL cover: ADD a=200 b=100 -> result=44, carry=1, zero=0, out_valid 1 cycle after acceptance.
REQ-034 The bench SHALL cover: SUB a=5 b=5 -> result=0, zero=1, carry=0; then EQ a=7 b=7 -> result=0.
REQ-035 The bench SHALL cover: MUL a=20 b=15 (macro on) -> result=44 (300 mod 256), ovf=1, out_valid exactly 9 cycles after acceptance; macro off -> err=1 at 1 cycle.
REQ-036 The bench SHALL cover: out_ready held low 5 cycles after ADD 3+4 -> result stays 7, in_ready stays 0 throughout, second in_valid ignored.
REQ-037 The bench SHALL cover: ADD 10+0, then use_acc ADD b=5 -> 15; op=111 -> err=1 with acc still 15; acc_clr -> subsequent use_acc ADD b=1 -> 1.
REQ-038 The bench SHALL cover: rst_n pulled low in the 4th MUL cycle -> out_valid=0 and in_ready=1 after release, acc=0.
